// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared mode encodings and frame helpers for the LED PWM array
package led_pkg;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_STEADY  = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;

  localparam int DEFAULT_STEP_CLKS = 12000;

  // Number of clocks in one colour PWM frame; a colour code of this value is fully on.
  function automatic int color_frame(input int color_w);
    return (1 << color_w) - 1;
  endfunction

endpackage

// File: rtl/led_channel.sv
// rtl/led_channel.sv - one RGB LED: active settings, breathe level, PWM compare, pin register
module led_channel
  import led_pkg::*;
#(
  parameter int COLOR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [COLOR_W-1:0]     cnt_color,
  input  logic [7:0]             env_step,
  input  logic                   breathe_tick,
  input  logic                   load,
  input  logic [3*COLOR_W-1:0]   load_color,
  input  logic [7:0]             load_dc,
  input  logic [1:0]             load_mode,
  output logic                   led_red,
  output logic                   led_green,
  output logic                   led_blue
);

  logic [3*COLOR_W-1:0] color_q, color_d;
  logic [7:0]           dc_q, dc_d;
  logic [1:0]           mode_q, mode_d;
  logic [7:0]           level_q, level_d;
  logic                 rising_q, rising_d;
  logic                 red_q, red_d;
  logic                 green_q, green_d;
  logic                 blue_q, blue_d;
  logic                 gate;

  // Breathe scales the colour code by level/256 so the whole LED fades uniformly.
  function automatic logic pwm_on(input logic [COLOR_W-1:0] cnt,
                                  input logic [COLOR_W-1:0] value,
                                  input logic [7:0]         level,
                                  input logic               breathe);
    logic [COLOR_W-1:0] eff;
    eff = breathe ? COLOR_W'(({8'd0, value} * {{COLOR_W{1'b0}}, level}) >> 8) : value;
    return cnt < eff;
  endfunction

  // Next active settings and breathe triangle; entering BREATHE restarts the ramp from dark.
  always_comb begin
    color_d  = color_q;
    dc_d     = dc_q;
    mode_d   = mode_q;
    level_d  = level_q;
    rising_d = rising_q;
    if (breathe_tick) begin
      if (rising_q) begin
        if (level_q == 8'hFF) rising_d = 1'b0;
        else                  level_d  = level_q + 8'd1;
      end else begin
        if (level_q == 8'h00) rising_d = 1'b1;
        else                  level_d  = level_q - 8'd1;
      end
    end
    if (load) begin
      color_d = load_color;
      dc_d    = load_dc;
      mode_d  = load_mode;
      if (load_mode == MODE_BREATHE && mode_q != MODE_BREATHE) begin
        level_d  = 8'd0;
        rising_d = 1'b1;
      end
    end
  end

  // Envelope gate and per-colour compare feeding the pin register.
  always_comb begin
    gate = 1'b0;
    case (mode_q)
      MODE_OFF:    gate = 1'b0;
      MODE_STEADY: gate = 1'b1;
      MODE_BLINK:  gate = (env_step < dc_q) || (dc_q == 8'hFF);
      default:     gate = 1'b1;
    endcase
    red_d   = gate & pwm_on(cnt_color, color_q[2*COLOR_W +: COLOR_W], level_q, mode_q == MODE_BREATHE);
    green_d = gate & pwm_on(cnt_color, color_q[COLOR_W +: COLOR_W],   level_q, mode_q == MODE_BREATHE);
    blue_d  = gate & pwm_on(cnt_color, color_q[0 +: COLOR_W],         level_q, mode_q == MODE_BREATHE);
  end

  // Channel state; reset drops the pins immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      color_q  <= '0;
      dc_q     <= '0;
      mode_q   <= MODE_OFF;
      level_q  <= '0;
      rising_q <= 1'b1;
      red_q    <= 1'b0;
      green_q  <= 1'b0;
      blue_q   <= 1'b0;
    end else begin
      color_q  <= color_d;
      dc_q     <= dc_d;
      mode_q   <= mode_d;
      level_q  <= level_d;
      rising_q <= rising_d;
      red_q    <= red_d;
      green_q  <= green_d;
      blue_q   <= blue_d;
    end
  end

  assign led_red   = red_q;
  assign led_green = green_q;
  assign led_blue  = blue_q;

endmodule

// File: rtl/led_pwm_array.sv
// rtl/led_pwm_array.sv - shared time bases, staging and frame-aligned loading for N RGB LEDs
module led_pwm_array
  import led_pkg::*;
#(
  parameter int N_LEDS      = 3,
  parameter int COLOR_W     = 8,
  parameter int STEP_CLKS   = DEFAULT_STEP_CLKS,
  parameter int BREATHE_DIV = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_LEDS*3*COLOR_W-1:0] color_value,
  input  logic [N_LEDS*8-1:0]         dc_value,
  input  logic [N_LEDS*2-1:0]         mode,
  input  logic                        update,
  output logic [N_LEDS-1:0]           led_red,
  output logic [N_LEDS-1:0]           led_green,
  output logic [N_LEDS-1:0]           led_blue,
  output logic                        frame_sync
);

  localparam int STEP_W = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;
  localparam int DIV_W  = (BREATHE_DIV > 1) ? $clog2(BREATHE_DIV) : 1;
  localparam logic [COLOR_W-1:0] LAST_COLOR = COLOR_W'(color_frame(COLOR_W) - 1);
  localparam logic [STEP_W-1:0]  LAST_STEP  = STEP_W'(STEP_CLKS - 1);
  localparam logic [DIV_W-1:0]   LAST_DIV   = DIV_W'(BREATHE_DIV - 1);

  logic [COLOR_W-1:0]          cnt_color_q, cnt_color_d;
  logic [STEP_W-1:0]           cnt_step_q, cnt_step_d;
  logic [7:0]                  env_step_q, env_step_d;
  logic [DIV_W-1:0]            div_q, div_d;
  logic [N_LEDS*3*COLOR_W-1:0] stg_color_q, stg_color_d;
  logic [N_LEDS*8-1:0]         stg_dc_q, stg_dc_d;
  logic [N_LEDS*2-1:0]         stg_mode_q, stg_mode_d;
  logic                        pending_q, pending_d;

  logic                        wrap;
  logic                        step_wrap;
  logic                        breathe_tick;
  logic                        load;
  logic [N_LEDS*3*COLOR_W-1:0] src_color;
  logic [N_LEDS*8-1:0]         src_dc;
  logic [N_LEDS*2-1:0]         src_mode;

  // Free-running colour frame, envelope step and breathe divider shared by every LED.
  always_comb begin
    wrap         = (cnt_color_q == LAST_COLOR);
    step_wrap    = (cnt_step_q == LAST_STEP);
    breathe_tick = step_wrap && (div_q == LAST_DIV);
    cnt_color_d  = wrap ? '0 : cnt_color_q + COLOR_W'(1);
    cnt_step_d   = step_wrap ? '0 : cnt_step_q + STEP_W'(1);
    env_step_d   = step_wrap ? env_step_q + 8'd1 : env_step_q;
    div_d        = div_q;
    if (step_wrap) div_d = (div_q == LAST_DIV) ? '0 : div_q + DIV_W'(1);
  end

  // Staging holds the latest request; an update on the wrap itself bypasses staging.
  always_comb begin
    stg_color_d = update ? color_value : stg_color_q;
    stg_dc_d    = update ? dc_value    : stg_dc_q;
    stg_mode_d  = update ? mode        : stg_mode_q;
    pending_d   = pending_q;
    if (update) pending_d = 1'b1;
    if (wrap)   pending_d = 1'b0;
    load      = wrap && (update || pending_q);
    src_color = update ? color_value : stg_color_q;
    src_dc    = update ? dc_value    : stg_dc_q;
    src_mode  = update ? mode        : stg_mode_q;
  end

  // Shared counters and staging registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_color_q <= '0;
      cnt_step_q  <= '0;
      env_step_q  <= '0;
      div_q       <= '0;
      stg_color_q <= '0;
      stg_dc_q    <= '0;
      stg_mode_q  <= '0;
      pending_q   <= 1'b0;
    end else begin
      cnt_color_q <= cnt_color_d;
      cnt_step_q  <= cnt_step_d;
      env_step_q  <= env_step_d;
      div_q       <= div_d;
      stg_color_q <= stg_color_d;
      stg_dc_q    <= stg_dc_d;
      stg_mode_q  <= stg_mode_d;
      pending_q   <= pending_d;
    end
  end

  assign frame_sync = wrap;

  for (genvar g = 0; g < N_LEDS; g++) begin : g_led
    led_channel #(
      .COLOR_W(COLOR_W)
    ) u_channel (
      .clk          (clk),
      .rst          (rst),
      .cnt_color    (cnt_color_q),
      .env_step     (env_step_q),
      .breathe_tick (breathe_tick),
      .load         (load),
      .load_color   (src_color[g*3*COLOR_W +: 3*COLOR_W]),
      .load_dc      (src_dc[g*8 +: 8]),
      .load_mode    (src_mode[g*2 +: 2]),
      .led_red      (led_red[g]),
      .led_green    (led_green[g]),
      .led_blue     (led_blue[g])
    );
  end

endmodule
